// File: rtl/bm_stage_sequencer.sv
`default_nettype none
// ============================================================================
// bm_stage_sequencer : walks the bitonic (phase, step) schedule for one reused
//                      compare-exchange unit; watchdog per stage. Rev 1.0
// ============================================================================
module bm_stage_sequencer #(
  parameter int LOG_N   = 3,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sort_ascending,
  input  logic             y_valid,
  output logic             ready,
  output logic             busy,
  output logic             x_valid,
  output logic             last_stage_chann,
  output logic             ASCENDING,
  output logic [IDX_W-1:0] phase,
  output logic [IDX_W-1:0] step,
  output logic [15:0]      stage_cnt,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(LOG_N);
  localparam logic [15:0]      WD_LIMIT   = 16'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] phase_nxt, step_nxt;
  logic [15:0]      cnt_nxt, wd, wd_nxt;
  logic             asc_nxt;
  logic             final_stage;
  logic             last_nxt;

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    step_nxt    = step;
    cnt_nxt     = stage_cnt;
    wd_nxt      = wd;
    asc_nxt     = ASCENDING;
    final_stage = (step == '0) && (phase == LAST_PHASE);

    case (state)
      S_IDLE: begin
        if (start) begin
          asc_nxt   = sort_ascending;
          phase_nxt = IDX_W'(1);
          step_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_nxt    = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (y_valid) begin
          cnt_nxt = stage_cnt + 16'd1;
          if (final_stage) begin
            state_nxt = S_DONE;
          end else begin
            if (step == '0) begin
              phase_nxt = phase + IDX_W'(1);
              step_nxt  = phase;
            end else begin
              step_nxt = step - IDX_W'(1);
            end
            state_nxt = S_ISSUE;
          end
        end else if (wd == WD_LIMIT) begin
          state_nxt = S_ERR;
        end else begin
          wd_nxt = wd + 16'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    last_nxt = ((state_nxt == S_ISSUE) || (state_nxt == S_WAIT)) &&
               (step_nxt == '0) && (phase_nxt == LAST_PHASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= IDX_W'(1);
      step      <= '0;
      stage_cnt <= '0;
      wd        <= '0;
      ASCENDING <= 1'b1;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      step      <= step_nxt;
      stage_cnt <= cnt_nxt;
      wd        <= wd_nxt;
      ASCENDING <= asc_nxt;
    end
  end

  // Strobes are registered decodes of the next state, so none depend on inputs combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready            <= 1'b1;
      busy             <= 1'b0;
      x_valid          <= 1'b0;
      last_stage_chann <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      ready            <= (state_nxt == S_IDLE);
      busy             <= (state_nxt != S_IDLE);
      x_valid          <= (state_nxt == S_ISSUE);
      last_stage_chann <= last_nxt;
      done             <= (state_nxt == S_DONE);
      err              <= (state_nxt == S_ERR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bm_stage_sequencer.sv
`default_nettype none
// ============================================================================
// tb_bm_stage_sequencer : directed scoreboard bench for bm_stage_sequencer
// Rev 1.0
// ============================================================================
module tb_bm_stage_sequencer;

  localparam int LOG_N   = 3;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int S       = LOG_N * (LOG_N + 1) / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sort_ascending = 1'b1;
  logic        y_valid = 1'b0;
  logic        ready, busy, x_valid, last_stage_chann, ASCENDING, done, err;
  logic [IDX_W-1:0] phase, step;
  logic [15:0] stage_cnt;

  typedef struct packed {
    logic [IDX_W-1:0] p;
    logic [IDX_W-1:0] q;
    logic             last;
  } ent_t;

  ent_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   exp_cnt = 0;

  bm_stage_sequencer #(.LOG_N(LOG_N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .sort_ascending(sort_ascending),
    .y_valid(y_valid), .ready(ready), .busy(busy), .x_valid(x_valid),
    .last_stage_chann(last_stage_chann), .ASCENDING(ASCENDING),
    .phase(phase), .step(step), .stage_cnt(stage_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_strobes", {ready, busy, x_valid, last_stage_chann, done, err, ASCENDING}, 32'b1000001);
    chk("rst_phase", phase, 1);
    chk("rst_step", step, 0);
    chk("rst_cnt", stage_cnt, 0);
  endtask

  // lat: y_valid delay after x_valid; hang: stage never answered; abort_at: reset in that stage's WAIT
  task automatic run_sort(input int lat, input bit asc, input bit noise, input int hang, input int abort_at);
    int   since, idx, t_start, t_x;
    bit   fin, aborted;
    ent_t e;
    sb.delete();
    if (noise) begin
      y_valid = 1'b1;
      @(negedge clk);
      y_valid = 1'b0;
      @(negedge clk);
      chk("idle_yvalid_cnt", stage_cnt, exp_cnt);
      chk("idle_yvalid_ready", ready, 1);
    end
    chk("pre_ready", ready, 1);
    start = 1'b1;
    sort_ascending = asc;
    for (int p = 1; p <= LOG_N; p++)
      for (int q = p - 1; q >= 0; q--)
        sb.push_back('{p: IDX_W'(p), q: IDX_W'(q), last: (p == LOG_N && q == 0)});
    @(negedge clk);
    start = 1'b0;
    t_start = cyc; t_x = cyc; since = 0; idx = 0; fin = 0; aborted = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      y_valid = 1'b0;
      start   = 1'b0;
      if (x_valid) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("issue_phase", phase, e.p);
          chk("issue_step", step, e.q);
          chk("issue_last", last_stage_chann, e.last);
        end
        chk("issue_asc", ASCENDING, asc);
        chk("issue_busy_ready", {busy, ready}, 2'b10);
        idx++; since = 0; t_x = cyc;
        if (noise) begin y_valid = 1'b1; start = 1'b1; end
      end else if (done) begin
        chk("done_latency", cyc - t_start + 1, S * (lat + 1) + 1);
        chk("done_cnt", stage_cnt, S);
        chk("done_sb_empty", sb.size(), 0);
        exp_cnt = S; fin = 1;
      end else if (err) begin
        chk("err_time", cyc - t_x, TIMEOUT + 1);
        chk("err_cnt", stage_cnt, hang - 1);
        exp_cnt = hang - 1; fin = 1;
        sb.delete();
      end else begin
        since++;
        chk("wait_last", last_stage_chann, idx == S);
        if (abort_at == idx && since == 1) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk_reset_vals();
          exp_cnt = 0; fin = 1; aborted = 1;
          sb.delete();
        end else begin
          if (since == lat && idx != hang) y_valid = 1'b1;
          if (noise && since == 1) start = 1'b1;
        end
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("cycle_budget", 0, 1);
    if (!aborted) @(negedge clk);
    chk("post_ready_busy", {ready, busy}, 2'b10);
    chk("post_cnt_hold", stage_cnt, exp_cnt);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals();
    @(negedge clk);
    chk_reset_vals();
    run_sort(1, 1'b0, 1'b0, 0, 0);   // clean descending run, L=1
    chk("held_phase", phase, LOG_N);
    chk("held_step", step, 0);
    chk("held_asc", ASCENDING, 0);
    run_sort(1, 1'b0, 1'b1, 0, 0);   // spurious y_valid/start noise
    run_sort(1, 1'b1, 1'b0, 2, 0);   // stage 2 never answered -> err
    run_sort(TIMEOUT, 1'b1, 1'b0, 0, 0); // y_valid exactly at watchdog limit
    run_sort(3, 1'b0, 1'b0, 0, 4);   // reset during WAIT of stage 4
    run_sort(1, 1'b1, 1'b0, 0, 0);   // full sort after abort
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bm_stage_sequencer.md
# bm_stage_sequencer

Control sequencer for a folded bitonic sorter in which one merge-block channel unit is reused for every compare-exchange stage. On each accepted sort request it walks the full bitonic schedule: phase p = 1..LOG_N, step q = p-1 down to 0, for LOG_N·(LOG_N+1)/2 stages. For each stage it issues one datapath pass, waits for the datapath's completion strobe, and then advances. It drives the channel unit's x_valid, last_stage_chann and ASCENDING inputs, and exports the stage indices to the routing/shuffle logic.

## Interface
- LOG_N, default 3 — log2 of elements sorted (N = 2^LOG_N); legal 1..8
- IDX_W, default 4 — width of phase/step outputs; must satisfy 2^IDX_W > LOG_N
- TIMEOUT, default 255 — max cycles to wait for y_valid per stage; legal 1..65535

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  sort request; accepted only when ready=1
- sort_ascending  in  1  requested final order, sampled on accepted start
- y_valid  in  1  datapath stage-complete strobe (from channel unit)
- ready  out  1  high in IDLE only
- busy  out  1  high from cycle after accepted start until done/err pulse cycle inclusive
- x_valid  out  1  one-cycle stage issue strobe to datapath
- last_stage_chann  out  1  high throughout ISSUE and WAIT of final stage (p=LOG_N, q=0)
- ASCENDING  out  1  latched sort_ascending, stable for whole sort
- phase  out  IDX_W  current phase p (1..LOG_N)
- step  out  IDX_W  current step q (compare distance 2^q)
- stage_cnt  out  16  stages completed in current/last sort
- done  out  1  one-cycle pulse, sort finished
- err  out  1  one-cycle pulse, per-stage timeout expired

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: ready=1. On start=1:
  - latch ASCENDING ← sort_ascending
  - phase←1, step←0, stage_cnt←0
  - go to ISSUE.
- ISSUE: x_valid=1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT: x_valid=0; watchdog increments each cycle.
  - If y_valid=1: stage_cnt+1.
    - If step=0 and phase=LOG_N: go to DONE.
    - Else if step=0: phase+1, step←phase (new phase-1).
    - Else: step−1.
    - In both non-final cases, go to ISSUE.
  - Else if watchdog reaches TIMEOUT: go to ERR.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE. stage_cnt holds the count reached.
- y_valid outside WAIT is ignored and does not affect counters.
- start outside IDLE is ignored. There is no queuing.
- phase/step/ASCENDING hold their values in DONE/ERR/IDLE until the next accepted start.
- y_valid arriving in the same cycle the watchdog reaches TIMEOUT counts as completion; it is not an error.

## Timing
- Reset values:
  - state IDLE
  - ready=1; busy=0, x_valid=0, last_stage_chann=0, done=0, err=0
  - ASCENDING=1, phase=1, step=0, stage_cnt=0
- Reset mid-sort aborts immediately to the reset values. No done/err pulse is produced.
- Start accepted at edge T:
  - ISSUE is cycle T+1, with x_valid=1.
  - busy=1 and ready=0 from T+1.
- If y_valid is seen L cycles after x_valid (L≥1):
  - Next x_valid occurs L+1 cycles after the previous one.
  - Sort latency from start to done: S·(L+1)+1 cycles, where S = LOG_N·(LOG_N+1)/2.
  - done is asserted in the cycle after the final y_valid.
- Watchdog: err is asserted TIMEOUT+1 cycles after the last x_valid if no y_valid arrives.
- ready returns to 1 the cycle after the done/err pulse. A new start is accepted in that same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: hold rst 2 cycles, release → ready=1, all strobes 0, phase=1, step=0, ASCENDING=1.
- LOG_N=3, start with sort_ascending=0, datapath model L=1:
  - (phase,step) sequence at x_valid is (1,0),(2,1),(2,0),(3,2),(3,1),(3,0)
  - last_stage_chann high only for (3,0)
  - ASCENDING=0 throughout
  - done exactly 13 cycles after start edge; stage_cnt=6.
- Spurious y_valid in IDLE and in ISSUE cycle, plus start pulses while busy → ignored; schedule and stage_cnt identical to the clean run.
- TIMEOUT=4, datapath never answers stage 2:
  - err pulse 5 cycles after second x_valid
  - stage_cnt=1, then ready=1.
- Boundary: y_valid arrives exactly when the watchdog hits TIMEOUT → stage completes, no err.
- Boundary: rst asserted during WAIT of stage 4 → next cycle shows reset values; a subsequent start runs a full 6-stage sort correctly.
